// File: rtl/trap_flush_ctrl.sv
// Write-back trap sequencer: turns a committed exception or ERTN into CSR update strobes,
// a timed pipeline flush and a handshaked fetch redirect, while blocking further WB commits.
module trap_flush_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned DROP_CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic                  excp_commit,
   input  logic                  ertn_flush,
   input  logic [5:0]            wb_ecode,
   input  logic [8:0]            wb_esubcode,
   input  logic [31:0]           wb_pc,
   input  logic [31:0]           csr_eentry,
   input  logic [31:0]           csr_era,
   input  logic                  if_redir_ready,
   output logic                  csr_excp_we,
   output logic                  csr_ertn_we,
   output logic [5:0]            trap_ecode,
   output logic [8:0]            trap_esubcode,
   output logic [31:0]           trap_pc,
   output logic                  flush_all,
   output logic                  commit_block,
   output logic                  redir_valid,
   output logic [31:0]           redir_pc,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned ECODE_W  = 6;
   localparam int unsigned ESUB_W   = 9;
   localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FLUSH = 2'd1,
      S_REDIR = 2'd2
   } state_e;

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [XLEN-1:0]        target_q;
   logic                   excp_we_q;
   logic                   ertn_we_q;
   logic                   flush_q;
   logic                   block_q;
   logic                   redir_valid_q;
   logic [ECODE_W-1:0]     ecode_q;
   logic [ESUB_W-1:0]      esub_q;
   logic [XLEN-1:0]        pc_q;
   logic [XLEN-1:0]        redir_pc_q;
   logic [DROP_CNT_W-1:0]  drop_cnt_q;
   logic [DROP_CNT_W-1:0]  drop_cnt_d;
   logic                   exc_c;
   logic                   ert_c;

   assign exc_c = wb_valid & excp_commit;
   assign ert_c = wb_valid & ertn_flush;

   // Events arriving while a sequence is in flight are counted, saturating at all-ones.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if ((state_q != S_IDLE) && (exc_c || ert_c) && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         target_q      <= '0;
         excp_we_q     <= 1'b0;
         ertn_we_q     <= 1'b0;
         flush_q       <= 1'b0;
         block_q       <= 1'b0;
         redir_valid_q <= 1'b0;
         ecode_q       <= '0;
         esub_q        <= '0;
         pc_q          <= '0;
         redir_pc_q    <= '0;
         drop_cnt_q    <= '0;
      end else begin
         excp_we_q  <= 1'b0;
         ertn_we_q  <= 1'b0;
         drop_cnt_q <= drop_cnt_d;
         case (state_q)
            S_IDLE: begin
               // Exception wins over a simultaneous ERTN; the losing ERTN is simply discarded.
               if (exc_c) begin
                  ecode_q   <= wb_ecode;
                  esub_q    <= wb_esubcode;
                  pc_q      <= wb_pc;
                  target_q  <= csr_eentry;
                  excp_we_q <= 1'b1;
                  flush_q   <= 1'b1;
                  block_q   <= 1'b1;
                  cnt_q     <= CNT_W'(FLUSH_CYCLES - 1);
                  state_q   <= S_FLUSH;
               end else if (ert_c) begin
                  target_q  <= csr_era;
                  ertn_we_q <= 1'b1;
                  flush_q   <= 1'b1;
                  block_q   <= 1'b1;
                  cnt_q     <= CNT_W'(FLUSH_CYCLES - 1);
                  state_q   <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  flush_q       <= 1'b0;
                  redir_valid_q <= 1'b1;
                  redir_pc_q    <= target_q & PC_ALIGN_MASK;
                  state_q       <= S_REDIR;
               end
            end
            S_REDIR: begin
               if (redir_valid_q && if_redir_ready) begin
                  redir_valid_q <= 1'b0;
                  block_q       <= 1'b0;
                  state_q       <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign csr_excp_we   = excp_we_q;
   assign csr_ertn_we   = ertn_we_q;
   assign trap_ecode    = ecode_q;
   assign trap_esubcode = esub_q;
   assign trap_pc       = pc_q;
   assign flush_all     = flush_q;
   assign commit_block  = block_q;
   assign redir_valid   = redir_valid_q;
   assign redir_pc      = redir_pc_q;
   assign drop_cnt      = drop_cnt_q;

endmodule
